// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - control/status bundle between the sequencer and its datapath/memory
interface cpu_sequencer_if;
  logic        start;
  logic [3:0]  opcode;
  logic        mem_ready;
  logic        zero;
  logic        f;
  logic        d;
  logic        e;
  logic        m;
  logic        w;
  logic        mem_req;
  logic        mem_we;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_load;
  logic        reg_we;
  logic        busy;
  logic        halted;
  logic        illegal_op;
  logic [15:0] instr_count;

  modport master (
    input  start, opcode, mem_ready, zero,
    output f, d, e, m, w, mem_req, mem_we, ir_load, pc_inc, pc_load, reg_we,
    output busy, halted, illegal_op, instr_count
  );

  modport slave (
    output start, opcode, mem_ready, zero,
    input  f, d, e, m, w, mem_req, mem_we, ir_load, pc_inc, pc_load, reg_we,
    input  busy, halted, illegal_op, instr_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle instruction sequencer (fetch/decode/exec/mem/wb)
module cpu_sequencer (
  input  logic              clk,
  input  logic              rst,
  cpu_sequencer_if.master   bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_ALU   = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_JMP   = 4'd4;
  localparam logic [3:0] OP_BZ    = 4'd5;
  localparam logic [3:0] OP_HALT  = 4'd15;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        f_q, f_d, d_q, d_d, e_q, e_d, m_q, m_d, w_q, w_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, reg_we_q, reg_we_d;
  logic        busy_q, busy_d, halted_q, halted_d, illegal_op_q, illegal_op_d;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    instr_count_d = instr_count_q;
    unique case (state_q)
      S_IDLE, S_HALT: if (bus.start) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) begin
          instr_count_d = instr_count_q + 16'd1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = (bus.opcode == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_ALU)                              state_d = S_WB;
        else if (op_q == OP_LOAD || op_q == OP_STORE)    state_d = S_MEM;
        else                                             state_d = S_FETCH;
      end
      S_MEM: if (bus.mem_ready) state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    // State-owned outputs are precomputed from the next state so they leave the flops aligned with it.
    f_d          = (state_d == S_FETCH);
    d_d          = (state_d == S_DECODE);
    e_d          = (state_d == S_EXEC);
    m_d          = (state_d == S_MEM);
    w_d          = (state_d == S_WB);
    mem_req_d    = f_d || m_d;
    mem_we_d     = m_d && (op_d == OP_STORE);
    reg_we_d     = w_d;
    busy_d       = f_d || d_d || e_d || m_d || w_d;
    halted_d     = (state_d == S_HALT);
    illegal_op_d = e_d && (op_d inside {[4'd6:4'd14]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= 4'd0;
      instr_count_q <= 16'd0;
      f_q           <= 1'b0;
      d_q           <= 1'b0;
      e_q           <= 1'b0;
      m_q           <= 1'b0;
      w_q           <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      reg_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      illegal_op_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      instr_count_q <= instr_count_d;
      f_q           <= f_d;
      d_q           <= d_d;
      e_q           <= e_d;
      m_q           <= m_d;
      w_q           <= w_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      reg_we_q      <= reg_we_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      illegal_op_q  <= illegal_op_d;
    end
  end

  // These follow live inputs so the datapath acts in the same cycle memory or the flag answers.
  assign bus.ir_load = (state_q == S_FETCH) && bus.mem_ready;
  assign bus.pc_inc  = (state_q == S_FETCH) && bus.mem_ready;
  assign bus.pc_load = (state_q == S_EXEC) &&
                       ((op_q == OP_JMP) || ((op_q == OP_BZ) && bus.zero));

  assign bus.f           = f_q;
  assign bus.d           = d_q;
  assign bus.e           = e_q;
  assign bus.m           = m_q;
  assign bus.w           = w_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.reg_we      = reg_we_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.illegal_op  = illegal_op_q;
  assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_sequencer_if bus ();
  cpu_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  // Output vector: f d e m w mem_req mem_we ir_load pc_inc pc_load reg_we busy halted illegal_op
  localparam logic [13:0] B_F    = 14'h2000;
  localparam logic [13:0] B_D    = 14'h1000;
  localparam logic [13:0] B_E    = 14'h0800;
  localparam logic [13:0] B_M    = 14'h0400;
  localparam logic [13:0] B_W    = 14'h0200;
  localparam logic [13:0] B_REQ  = 14'h0100;
  localparam logic [13:0] B_WE   = 14'h0080;
  localparam logic [13:0] B_IRL  = 14'h0040;
  localparam logic [13:0] B_PCI  = 14'h0020;
  localparam logic [13:0] B_PCL  = 14'h0010;
  localparam logic [13:0] B_RWE  = 14'h0008;
  localparam logic [13:0] B_BUSY = 14'h0004;
  localparam logic [13:0] B_HALT = 14'h0002;
  localparam logic [13:0] B_ILL  = 14'h0001;

  localparam logic [13:0] V_IDLE = 14'h0000;
  localparam logic [13:0] V_F    = B_F | B_REQ | B_BUSY;
  localparam logic [13:0] V_FR   = V_F | B_IRL | B_PCI;
  localparam logic [13:0] V_D    = B_D | B_BUSY;
  localparam logic [13:0] V_E    = B_E | B_BUSY;
  localparam logic [13:0] V_M    = B_M | B_REQ | B_BUSY;
  localparam logic [13:0] V_MS   = V_M | B_WE;
  localparam logic [13:0] V_W    = B_W | B_RWE | B_BUSY;
  localparam logic [13:0] V_H    = B_HALT;

  logic [29:0] exp_q[$];
  string       tag_q[$];
  int          total  = 0;
  int          passed = 0;
  logic [15:0] exp_count = 16'd0;

  function automatic logic [13:0] observed();
    return {bus.f, bus.d, bus.e, bus.m, bus.w, bus.mem_req, bus.mem_we, bus.ir_load,
            bus.pc_inc, bus.pc_load, bus.reg_we, bus.busy, bus.halted, bus.illegal_op};
  endfunction

  // One clock cycle: queue the expectation, compare mid-cycle, then advance past the edge.
  task automatic cyc(input logic [13:0] exp, input string tag);
    logic [29:0] e;
    logic [29:0] o;
    string       t;
    exp_q.push_back({exp_count, exp});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {bus.instr_count, observed()};
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed count=%h vec=%b, expected count=%h vec=%b",
                t, o[29:14], o[13:0], e[29:14], e[13:0]);
    @(posedge clk);
    #1;
    if (exp[6]) exp_count = exp_count + 16'd1;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.opcode = 4'd0;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(V_IDLE, "reset_idle");
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    cyc(V_IDLE, "idle_hold");

    bus.opcode = 4'd1;
    bus.start = 1'b1;
    cyc(V_IDLE, "idle_start");
    bus.start = 1'b0;
    cyc(V_FR, "alu_fetch");
    cyc(V_D, "alu_decode");
    cyc(V_E, "alu_exec");
    bus.opcode = 4'd2;
    cyc(V_W, "alu_wb");

    cyc(V_FR, "load_fetch");
    cyc(V_D, "load_decode");
    bus.mem_ready = 1'b0;
    bus.start = 1'b1;
    cyc(V_E, "load_exec");
    cyc(V_M, "load_mem_wait0");
    cyc(V_M, "load_mem_wait1");
    cyc(V_M, "load_mem_wait2");
    bus.start = 1'b0;
    bus.mem_ready = 1'b1;
    cyc(V_M, "load_mem_done");
    bus.opcode = 4'd3;
    cyc(V_W, "load_wb");

    cyc(V_FR, "store_fetch");
    cyc(V_D, "store_decode");
    cyc(V_E, "store_exec");
    cyc(V_MS, "store_mem");
    bus.opcode = 4'd5;
    bus.mem_ready = 1'b0;
    cyc(V_F, "fetch_stall");
    bus.mem_ready = 1'b1;
    cyc(V_FR, "bz0_fetch");
    cyc(V_D, "bz0_decode");
    cyc(V_E, "bz0_exec");
    bus.zero = 1'b1;
    cyc(V_FR, "bz1_fetch");
    cyc(V_D, "bz1_decode");
    cyc(V_E | B_PCL, "bz1_exec");
    bus.zero = 1'b0;
    bus.opcode = 4'd4;
    cyc(V_FR, "jmp_fetch");
    cyc(V_D, "jmp_decode");
    cyc(V_E | B_PCL, "jmp_exec");
    bus.opcode = 4'd9;
    cyc(V_FR, "ill_fetch");
    cyc(V_D, "ill_decode");
    cyc(V_E | B_ILL, "ill_exec");
    bus.opcode = 4'd15;
    cyc(V_FR, "halt_fetch");
    cyc(V_D, "halt_decode");
    for (int i = 0; i < 5; i++) cyc(V_H, "halt_wait");
    bus.opcode = 4'd0;
    bus.start = 1'b1;
    cyc(V_H, "halt_start");
    bus.start = 1'b0;
    cyc(V_FR, "nop_fetch");
    cyc(V_D, "nop_decode");
    cyc(V_E, "nop_exec");

    bus.opcode = 4'd2;
    cyc(V_FR, "rst_load_fetch");
    cyc(V_D, "rst_load_decode");
    bus.mem_ready = 1'b0;
    cyc(V_E, "rst_load_exec");
    cyc(V_M, "rst_mem");
    rst = 1'b1;
    cyc(V_M, "rst_mem_edge");
    rst = 1'b0;
    exp_count = 16'd0;
    cyc(V_IDLE, "after_mem_rst");

    force dut.instr_count_q = 16'hFFFF;
    exp_count = 16'hFFFF;
    cyc(V_IDLE, "preload");
    release dut.instr_count_q;
    cyc(V_IDLE, "preload_hold");
    bus.opcode = 4'd0;
    bus.mem_ready = 1'b1;
    bus.start = 1'b1;
    cyc(V_IDLE, "wrap_start");
    bus.start = 1'b0;
    cyc(V_FR, "wrap_fetch");
    cyc(V_D, "wrap_decode");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have: clk  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have: start  in  1  leave IDLE or HALT and begin fetching.
REQ-004 SHALL have: opcode  in  4  instruction opcode from the IR, sampled in DECODE only.
REQ-005 SHALL have: mem_ready  in  1  memory completes the current request this cycle.
REQ-006 SHALL have: zero  in  1  ALU zero flag, used by BZ in EXEC.
REQ-007 SHALL have: f, d, e, m, w  out  1 each  phase strobes FETCH/DECODE/EXEC/MEM/WB; at most one high.
REQ-008 SHALL have: mem_req, mem_we, ir_load, pc_inc, pc_load, reg_we  out  1 each  datapath controls.
REQ-009 SHALL have: busy, halted, illegal_op  out  1 each  status.
REQ-010 SHALL have: instr_count  out  16  number of instructions fetched.

Function
REQ-011 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-012 SHALL decode opcodes: 0 NOP, 1 ALU, 2 LOAD, 3 STORE, 4 JMP, 5 BZ, 15 HALT; 6-14 are illegal.
REQ-013 IDLE: all strobes and controls low; start=1 -> FETCH next cycle; otherwise stay.
REQ-014 FETCH: f=1, mem_req=1, mem_we=0; hold until mem_ready=1.
REQ-015 FETCH with mem_ready=1: same cycle ir_load=1, pc_inc=1, instr_count+1; -> DECODE.
REQ-016 DECODE: d=1 for exactly one cycle; latch opcode into an internal op register.
REQ-017 DECODE: op=15 -> HALT; any other op -> EXEC.
REQ-018 EXEC: e=1 for exactly one cycle; next state by latched op:
  - ALU -> WB
  - LOAD/STORE -> MEM
  - JMP: pc_load=1 -> FETCH
  - BZ: pc_load=zero -> FETCH
  - NOP -> FETCH
  - illegal: illegal_op=1 for this cycle only, otherwise behave as NOP.
REQ-019 MEM: m=1, mem_req=1, mem_we=1 only for STORE; hold until mem_ready=1.
REQ-020 MEM with mem_ready=1: LOAD -> WB, STORE -> FETCH.
REQ-021 WB: w=1, reg_we=1 for exactly one cycle -> FETCH.
REQ-022 HALT: halted=1, all strobes/controls low; start=1 -> FETCH; otherwise stay.
REQ-023 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-024 start SHALL be ignored outside IDLE and HALT.
REQ-025 busy = 1 in FETCH, DECODE, EXEC, MEM and WB; 0 in IDLE and HALT.
REQ-026 Strobes and mem_req/mem_we/reg_we/busy/halted are functions of state; ir_load, pc_inc and pc_load may additionally depend on current inputs.
REQ-027 instr_count: 16-bit unsigned, wraps 0xFFFF -> 0x0000, no saturation.
REQ-028 Minimum latencies in cycles, fetch to next FETCH with mem_ready=1 on first cycle:
  - NOP/JMP/BZ: 3
  - ALU: 4
  - STORE: 4
  - LOAD: 5

Reset
REQ-029 rst=1 SHALL force IDLE, op=0, instr_count=0 and all outputs low on the next edge, from any state.
REQ-030 rst SHALL take priority over start, mem_ready and every transition.
REQ-031 Reset mid-MEM SHALL drop mem_req the cycle after the edge; no pending request is retained.

Verification
REQ-032 Reset, start=1 one cycle, mem_ready=1, opcode=1 -> f,d,e,w on cycles 1-4; reg_we=1 in cycle 4; back to f; instr_count=1.
REQ-033 LOAD with mem_ready low 3 cycles in MEM -> m=1, mem_req=1 for 4 cycles, mem_we=0, then w=1 one cycle.
REQ-034 STORE -> mem_we=1 only in MEM; no w cycle; FETCH follows MEM.
REQ-035 BZ with zero=0 gives pc_load=0; with zero=1 gives pc_load=1; JMP gives pc_load=1; all three return to FETCH.
REQ-036 Opcode 15 -> halted=1, busy=0; start after 5 idle cycles -> f=1 next cycle. Opcode 9 -> illegal_op pulses one cycle in EXEC.
REQ-037 Cover both boundary cases:
  - Preload via 65535 fetches -> next fetch gives instr_count=0x0000.
  - rst=1 during MEM -> IDLE, mem_req=0 and instr_count=0 next cycle.
